// File: rtl/pong_pkg.sv
// Shared types and constants for the pong input stage.
//   deb_state_e         : per-channel debounce FSM states
//   btn_idx_e           : bit positions of each button on the btns bus
//   DEBOUNCE_CYCLES_DEF : default hold time (10 ms at 125 MHz pclk)
package pong_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1250000;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        PEND_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        PEND_LOW    = 2'd3
    } deb_state_e;

    typedef enum int unsigned {
        BTN_P1_DN = 0,
        BTN_P1_UP = 1,
        BTN_P2_DN = 2,
        BTN_P2_UP = 3
    } btn_idx_e;

endpackage

// File: rtl/debounce_chan.sv
// Single-button conditioner: 2-FF synchroniser followed by a counter-based
// debounce FSM. Outputs are combinational (_c) so the parent can register
// them without adding a cycle of latency.
//   clk_i, rst_i  : pclk and asynchronous active-high reset
//   raw_i         : raw pad level, asynchronous to clk_i
//   level_c_o     : debounced level the channel holds after this edge
//   press_c_o     : high in the cycle a 0->1 is accepted
//   release_c_o   : high in the cycle a 1->0 is accepted
module debounce_chan
    import pong_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_c_o,
    output logic press_c_o,
    output logic release_c_o
);

    localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Synchroniser: plain flop-to-flop, nothing in between.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: any sample of the old level while pending discards progress.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            STABLE_LOW: begin
                cnt_d = '0;
                if (sync_q) begin
                    state_d = PEND_HIGH;
                    cnt_d   = CNT_W'(1);
                end
            end
            PEND_HIGH: begin
                if (!sync_q) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE_HIGH: begin
                cnt_d = '0;
                if (!sync_q) begin
                    state_d = PEND_LOW;
                    cnt_d   = CNT_W'(1);
                end
            end
            PEND_LOW: begin
                if (sync_q) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs: level follows the state being entered so the parent's
    // register lands on the acceptance edge itself.
    always_comb begin
        level_c_o   = (state_d == STABLE_HIGH) || (state_d == PEND_LOW);
        press_c_o   = (state_q == PEND_HIGH) && sync_q && (cnt_q == CNT_LAST);
        release_c_o = (state_q == PEND_LOW) && !sync_q && (cnt_q == CNT_LAST);
    end

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the raw board buttons into clean levels and edge pulses for
// the pong core. One debounce_chan per button; this level only holds the
// output registers and the optional opposing-direction lock.
// Build option: define OPPOSE_LOCK_EN to force both bits of a paddle pair
// (0,1) / (2,3) low while both are held; pulses are unaffected.
//   pclk        : pixel clock shared with the game core
//   reset       : asynchronous active-high reset
//   btn_raw     : raw pad inputs, asynchronous to pclk
//   btns        : debounced levels to the game core
//   btn_press   : one-cycle pulse per accepted 0->1
//   btn_release : one-cycle pulse per accepted 1->0
module btn_conditioner
    import pong_pkg::*;
#(
    parameter int unsigned N_BTNS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic [N_BTNS-1:0] btn_raw,
    output logic [N_BTNS-1:0] btns,
    output logic [N_BTNS-1:0] btn_press,
    output logic [N_BTNS-1:0] btn_release
);

    logic [N_BTNS-1:0] level_c;
    logic [N_BTNS-1:0] press_c;
    logic [N_BTNS-1:0] release_c;
    logic [N_BTNS-1:0] btns_d;
    logic [N_BTNS-1:0] btns_q;
    logic [N_BTNS-1:0] press_q;
    logic [N_BTNS-1:0] release_q;

    for (genvar i = 0; i < N_BTNS; i++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk_i       (pclk),
            .rst_i       (reset),
            .raw_i       (btn_raw[i]),
            .level_c_o   (level_c[i]),
            .press_c_o   (press_c[i]),
            .release_c_o (release_c[i])
        );
    end

    // Level presented to the core, optionally with opposing pairs cancelled.
    always_comb begin
        btns_d = level_c;
`ifdef OPPOSE_LOCK_EN
        for (int p = 0; p + 1 < int'(N_BTNS); p += 2) begin
            if (level_c[p] && level_c[p+1]) begin
                btns_d[p]   = 1'b0;
                btns_d[p+1] = 1'b0;
            end
        end
`endif
    end

    // Output registers.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            btns_q    <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            btns_q    <= btns_d;
            press_q   <= press_c;
            release_q <= release_c;
        end
    end

    assign btns        = btns_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner with DEBOUNCE_CYCLES = 8.
// Expected outputs come from a window model: a level flips on the edge where
// the last D synchronised samples all differ from it; synchronised sample at
// edge n is the raw value sampled at edge n-2 (zero just after reset).
module tb_btn_conditioner;
    import pong_pkg::*;

    localparam int unsigned NB  = 4;
    localparam int unsigned D   = 8;
    localparam int          LAT = int'(D) + 2;

    typedef struct packed {
        logic [NB-1:0] btns;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
    } out_t;

    logic          pclk;
    logic          reset;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btns;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;

    int n_cmp  = 0;
    int n_fail = 0;

    out_t          sb[$];
    logic [NB-1:0] samp[$];
    logic [NB-1:0] m_level;

    btn_conditioner #(
        .N_BTNS          (NB),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .pclk        (pclk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btns        (btns),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    function automatic logic [NB-1:0] exp_lock(input logic [NB-1:0] lvl);
        logic [NB-1:0] o;
        o = lvl;
`ifdef OPPOSE_LOCK_EN
        if (lvl[BTN_P1_DN] && lvl[BTN_P1_UP]) begin
            o[BTN_P1_DN] = 1'b0;
            o[BTN_P1_UP] = 1'b0;
        end
        if (lvl[BTN_P2_DN] && lvl[BTN_P2_UP]) begin
            o[BTN_P2_DN] = 1'b0;
            o[BTN_P2_UP] = 1'b0;
        end
`endif
        return o;
    endfunction

    // Push the expectation for the edge where this sample reaches the FSM.
    task automatic model_push(input logic [NB-1:0] raw);
        out_t e;
        bit   flip;
        e = '0;
        samp.push_back(raw);
        if (samp.size() > int'(D)) void'(samp.pop_front());
        for (int ch = 0; ch < int'(NB); ch++) begin
            flip = (samp.size() == int'(D));
            foreach (samp[j]) if (samp[j][ch] == m_level[ch]) flip = 1'b0;
            if (flip) begin
                m_level[ch] = ~m_level[ch];
                if (m_level[ch]) e.press[ch] = 1'b1;
                else             e.rel[ch]   = 1'b1;
            end
        end
        e.btns = exp_lock(m_level);
        sb.push_back(e);
    endtask

    task automatic model_reset();
        sb.delete();
        samp.delete();
        m_level = '0;
        model_push('0);
        model_push('0);
    endtask

    // Called at a negedge; drives one cycle and returns observed/expected.
    task automatic cycle_drive(input logic [NB-1:0] raw, output out_t act,
                               output out_t exp, output bit ok);
        btn_raw = raw;
        model_push(raw);
        @(posedge pclk);
        #1;
        act = {btns, btn_press, btn_release};
        ok  = (sb.size() != 0);
        exp = ok ? sb.pop_front() : '0;
        @(negedge pclk);
    endtask

    task automatic apply_reset(input int n);
        reset   = 1'b1;
        btn_raw = '0;
        repeat (n) @(negedge pclk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        out_t act, exp;
        bit   ok;
        int   rise_k  = -1;
        int   presses = 0;
        reset   = 1'b1;
        btn_raw = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            @(posedge pclk);
            #1;
            n_cmp++;
            if ({btns, btn_press, btn_release} !== '0) begin
                n_fail++;
                $display("FAIL reset_hold k=%0d got btns=%b press=%b rel=%b want 0", k, btns, btn_press, btn_release);
            end
        end
        @(negedge pclk);
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 14; k++) begin
            cycle_drive(4'b1111, act, exp, ok);
            n_cmp++;
            if (!ok || act !== exp) begin
                n_fail++;
                $display("FAIL reset_seq k=%0d got b/p/r=%h want %h", k, act, exp);
            end
            if (rise_k < 0 && act.btns == exp_lock(4'b1111) && act.press == 4'b1111) rise_k = k;
            presses += $countones(act.press);
        end
        n_cmp++;
        if (rise_k + 1 != LAT) begin
            n_fail++;
            $display("FAIL reset_latency got %0d want %0d", rise_k + 1, LAT);
        end
        n_cmp++;
        if (presses != 4) begin
            n_fail++;
            $display("FAIL reset_press_count got %0d want 4", presses);
        end
    endtask

    task automatic test_clean_press();
        out_t act, exp;
        bit   ok;
        int   rise_k = -1;
        int   presses = 0;
        logic [NB-1:0] others = '0;
        logic [NB-1:0] r = '0;
        apply_reset(2);
        r[BTN_P1_DN] = 1'b1;
        for (int k = 0; k < 14; k++) begin
            cycle_drive(r, act, exp, ok);
            n_cmp++;
            if (!ok || act !== exp) begin
                n_fail++;
                $display("FAIL clean_press k=%0d got b/p/r=%h want %h", k, act, exp);
            end
            if (rise_k < 0 && act.btns[BTN_P1_DN]) rise_k = k;
            presses += int'(act.press[BTN_P1_DN]);
            others  |= act.btns & ~r;
        end
        n_cmp++;
        if (rise_k + 1 != LAT) begin
            n_fail++;
            $display("FAIL clean_press_latency got %0d want %0d", rise_k + 1, LAT);
        end
        n_cmp++;
        if (presses != 1 || others != '0) begin
            n_fail++;
            $display("FAIL clean_press_pulse got presses=%0d others=%b want 1 and 0000", presses, others);
        end
    endtask

    task automatic test_bounce();
        out_t act, exp;
        bit   ok;
        int   press_k = -1;
        int   presses = 0;
        logic [NB-1:0] r;
        apply_reset(2);
        for (int k = 0; k < 26; k++) begin
            r = '0;
            r[BTN_P2_DN] = (k >= 12) ? 1'b1 : (((k / 3) % 2) == 0);
            cycle_drive(r, act, exp, ok);
            n_cmp++;
            if (!ok || act !== exp) begin
                n_fail++;
                $display("FAIL bounce k=%0d got b/p/r=%h want %h", k, act, exp);
            end
            if (press_k < 0 && act.press[BTN_P2_DN]) press_k = k;
            presses += int'(act.press[BTN_P2_DN]);
        end
        n_cmp++;
        if (press_k - 12 + 1 != LAT || presses != 1) begin
            n_fail++;
            $display("FAIL bounce_accept got latency=%0d presses=%0d want %0d and 1", press_k - 11, presses, LAT);
        end
    endtask

    task automatic test_glitch();
        out_t act, exp;
        bit   ok;
        int   seen = 0;
        logic [NB-1:0] r;
        apply_reset(2);
        for (int k = 0; k < 20; k++) begin
            r = '0;
            r[BTN_P2_UP] = (k < int'(D) - 1);
            cycle_drive(r, act, exp, ok);
            n_cmp++;
            if (!ok || act !== exp) begin
                n_fail++;
                $display("FAIL glitch k=%0d got b/p/r=%h want %h", k, act, exp);
            end
            if (act != '0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL glitch_leak got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_release();
        out_t act, exp;
        bit   ok;
        int   rel_k = -1;
        int   rels  = 0;
        logic [NB-1:0] r;
        apply_reset(2);
        for (int k = 0; k < 26; k++) begin
            r = '0;
            r[BTN_P1_DN] = (k < 12);
            cycle_drive(r, act, exp, ok);
            n_cmp++;
            if (!ok || act !== exp) begin
                n_fail++;
                $display("FAIL release k=%0d got b/p/r=%h want %h", k, act, exp);
            end
            if (act.press[BTN_P1_DN] && act.rel[BTN_P1_DN]) begin
                n_fail++;
                $display("FAIL release_overlap k=%0d got press and release together", k);
            end
            if (rel_k < 0 && act.rel[BTN_P1_DN]) rel_k = k;
            rels += int'(act.rel[BTN_P1_DN]);
        end
        n_cmp++;
        if (rel_k - 12 + 1 != LAT || rels != 1 || btns[BTN_P1_DN] !== 1'b0) begin
            n_fail++;
            $display("FAIL release_accept got latency=%0d pulses=%0d btn=%b want %0d 1 0", rel_k - 11, rels, btns[BTN_P1_DN], LAT);
        end
    endtask

    task automatic test_reset_mid_pending();
        out_t act, exp;
        bit   ok;
        int   press_k = -1;
        apply_reset(2);
        for (int k = 0; k < 19; k++) begin
            cycle_drive((k < 12) ? 4'b0100 : 4'b0101, act, exp, ok);
            n_cmp++;
            if (!ok || act !== exp) begin
                n_fail++;
                $display("FAIL mid_setup k=%0d got b/p/r=%h want %h", k, act, exp);
            end
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({btns, btn_press, btn_release} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_clear got btns=%b press=%b rel=%b want 0", btns, btn_press, btn_release);
        end
        repeat (2) @(negedge pclk);
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 14; k++) begin
            cycle_drive(4'b0101, act, exp, ok);
            n_cmp++;
            if (!ok || act !== exp) begin
                n_fail++;
                $display("FAIL mid_requal k=%0d got b/p/r=%h want %h", k, act, exp);
            end
            if (press_k < 0 && act.press[BTN_P1_DN]) press_k = k;
        end
        n_cmp++;
        if (press_k + 1 != LAT || btns !== 4'b0101) begin
            n_fail++;
            $display("FAIL mid_requal_latency got %0d btns=%b want %0d 0101", press_k + 1, btns, LAT);
        end
    endtask

    task automatic test_oppose();
        out_t act, exp;
        bit   ok;
        logic [NB-1:0] want_pair;
`ifdef OPPOSE_LOCK_EN
        want_pair = 4'b0000;
`else
        want_pair = 4'b0011;
`endif
        apply_reset(2);
        for (int k = 0; k < 28; k++) begin
            cycle_drive((k < 14) ? 4'b0011 : 4'b0001, act, exp, ok);
            n_cmp++;
            if (!ok || act !== exp) begin
                n_fail++;
                $display("FAIL oppose k=%0d got b/p/r=%h want %h", k, act, exp);
            end
            if (k == LAT - 1) begin
                n_cmp++;
                if (act.btns !== want_pair || act.press !== 4'b0011) begin
                    n_fail++;
                    $display("FAIL oppose_hold got btns=%b press=%b want %b 0011", act.btns, act.press, want_pair);
                end
            end
            if (k == 14 + LAT - 1) begin
                n_cmp++;
                if (act.btns !== 4'b0001 || act.rel !== 4'b0010) begin
                    n_fail++;
                    $display("FAIL oppose_release got btns=%b rel=%b want 0001 0010", act.btns, act.rel);
                end
            end
        end
    endtask

    task automatic test_independent();
        out_t act, exp;
        bit   ok;
        int   pk[NB];
        logic [NB-1:0] r;
        for (int i = 0; i < int'(NB); i++) pk[i] = -1;
        apply_reset(2);
        for (int k = 0; k < 20; k++) begin
            r = '0;
            r[BTN_P1_DN] = 1'b1;
            r[BTN_P2_UP] = (k >= 3);
            r[BTN_P1_UP] = (k >= 5);
            cycle_drive(r, act, exp, ok);
            n_cmp++;
            if (!ok || act !== exp) begin
                n_fail++;
                $display("FAIL independent k=%0d got b/p/r=%h want %h", k, act, exp);
            end
            for (int i = 0; i < int'(NB); i++)
                if (pk[i] < 0 && act.press[i]) pk[i] = k;
        end
        n_cmp++;
        if (pk[BTN_P1_DN] != 9 || pk[BTN_P2_UP] != 12 || pk[BTN_P1_UP] != 14 || pk[BTN_P2_DN] != -1) begin
            n_fail++;
            $display("FAIL independent_sched got %0d %0d %0d %0d want 9 14 -1 12",
                     pk[0], pk[1], pk[2], pk[3]);
        end
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = '0;
        m_level = '0;
        @(negedge pclk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_release();
        test_reset_mid_pending();
        test_oppose();
        test_independent();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
